// File: rtl/piso_framer_pkg.sv
// Shared types and helpers for the parallel-to-serial framer.
package piso_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} piso_state_t;

  // Bits needed to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_framer_if.sv
// Frame-in / serial-out bundle of the framer; master drives frames, slave is the framer.
interface piso_framer_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_NUM = 2
);
  logic [WIDTH*MAX_NUM-1:0] din_parallel;
  logic                     din_valid;
  logic                     din_ready;
  logic [WIDTH-1:0]         dout_serial;
  logic                     dout_valid;
  logic                     dout_last;
  logic                     busy;

  modport master (
    output din_parallel, din_valid,
    input  din_ready, dout_serial, dout_valid, dout_last, busy
  );

  modport slave (
    input  din_parallel, din_valid,
    output din_ready, dout_serial, dout_valid, dout_last, busy
  );
endinterface

// File: rtl/piso_framer.sv
// Serialises one packed frame into MAX_NUM contiguous word-beats followed by an idle gap.
// PISO_MSB_FIRST_EN: issue the top word first instead of word 0.
module piso_framer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_NUM    = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rstn,
  piso_framer_if.slave bus
);

  localparam int FW = WIDTH * MAX_NUM;
  localparam int BW = cnt_w(MAX_NUM);
  localparam int GW = cnt_w(GAP_CYCLES);

  piso_state_t       state_q, state_d;
  logic [FW-1:0]     sreg_q, sreg_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;

  // head: word emitted next; tail: remaining frame after that word is consumed.
  function automatic logic [WIDTH-1:0] head(input logic [FW-1:0] f);
`ifdef PISO_MSB_FIRST_EN
    return f[FW-1 -: WIDTH];
`else
    return f[WIDTH-1:0];
`endif
  endfunction

  function automatic logic [FW-1:0] tail(input logic [FW-1:0] f);
`ifdef PISO_MSB_FIRST_EN
    return f << WIDTH;
`else
    return f >> WIDTH;
`endif
  endfunction

  // beat_q counts words already placed on the output, including the one shown now.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    dout_d  = '0;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.din_valid) begin
          state_d = SHIFT;
          sreg_d  = tail(bus.din_parallel);
          dout_d  = head(bus.din_parallel);
          beat_d  = BW'(1);
          vld_d   = 1'b1;
          last_d  = (MAX_NUM == 1);
        end
      end
      SHIFT: begin
        if (beat_q == BW'(MAX_NUM)) begin
          beat_d  = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          sreg_d = tail(sreg_q);
          dout_d = head(sreg_q);
          beat_d = beat_q + 1'b1;
          vld_d  = 1'b1;
          last_d = (beat_q == BW'(MAX_NUM - 1));
        end
      end
      GAP: begin
        if (int'(gap_q) >= GAP_CYCLES - 1) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.din_ready   = (state_q == IDLE);
  assign bus.dout_serial = dout_q;
  assign bus.dout_valid  = vld_q;
  assign bus.dout_last   = last_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_piso_framer.sv
// Three framer configurations checked cycle by cycle against a schedule-based model
// plus a collector-style reassembly of every emitted frame.
module tb_piso_framer;

  localparam int WI [3] = '{8, 8, 4};
  localparam int NI [3] = '{2, 2, 1};
  localparam int GI [3] = '{0, 3, 0};
`ifdef PISO_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [2:0][15:0] drv_d;
  logic [2:0]       drv_v;
  logic [2:0]       o_v, o_l, o_r, o_b;
  logic [2:0][7:0]  o_s;

  piso_framer_if #(.WIDTH(8), .MAX_NUM(2)) if0 ();
  piso_framer_if #(.WIDTH(8), .MAX_NUM(2)) if1 ();
  piso_framer_if #(.WIDTH(4), .MAX_NUM(1)) if2 ();

  piso_framer #(.WIDTH(8), .MAX_NUM(2), .GAP_CYCLES(0)) u0 (.clk(clk), .rstn(rstn), .bus(if0));
  piso_framer #(.WIDTH(8), .MAX_NUM(2), .GAP_CYCLES(3)) u1 (.clk(clk), .rstn(rstn), .bus(if1));
  piso_framer #(.WIDTH(4), .MAX_NUM(1), .GAP_CYCLES(0)) u2 (.clk(clk), .rstn(rstn), .bus(if2));

  assign if0.din_parallel = drv_d[0];
  assign if1.din_parallel = drv_d[1];
  assign if2.din_parallel = drv_d[2][3:0];
  assign if0.din_valid = drv_v[0];
  assign if1.din_valid = drv_v[1];
  assign if2.din_valid = drv_v[2];

  assign o_v = {if2.dout_valid, if1.dout_valid, if0.dout_valid};
  assign o_l = {if2.dout_last,  if1.dout_last,  if0.dout_last};
  assign o_r = {if2.din_ready,  if1.din_ready,  if0.din_ready};
  assign o_b = {if2.busy,       if1.busy,       if0.busy};
  assign o_s[0] = if0.dout_serial;
  assign o_s[1] = if1.dout_serial;
  assign o_s[2] = {4'b0, if2.dout_serial};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected beats keyed by cycle*4+instance.
  logic [7:0]  exp_w [int];
  bit          exp_l [int];
  int          rdy_cyc [3];
  int          last_acc [3];
  bit          offering [3];
  bit          burst [3];
  logic [15:0] col [3];
  logic [15:0] src_q [3][$];
  logic [15:0] sent_q [3][$];

  function automatic logic [15:0] fmask(input int g);
    return (WI[g] * NI[g] >= 16) ? 16'hFFFF : 16'((32'd1 << (WI[g] * NI[g])) - 1);
  endfunction

  function automatic logic [7:0] word_of(input int g, input logic [15:0] f, input int k);
    logic [15:0] m;
    m = 16'((32'd1 << WI[g]) - 1);
    return 8'((f >> (k * WI[g])) & m);
  endfunction

  task automatic chk(input string tag, input int g, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cyc%0d: got %h want %h", tag, g, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input int g);
    int key;
    bit ev, el, er;
    logic [7:0] ew;
    key = cyc * 4 + g;
    ev  = exp_w.exists(key);
    ew  = ev ? exp_w[key] : 8'h00;
    el  = ev ? exp_l[key] : 1'b0;
    er  = (cyc >= rdy_cyc[g]);
    chk("ctl{valid,last,ready,busy}", g, {12'b0, o_v[g], o_l[g], o_r[g], o_b[g]},
        {12'b0, ev, el, er, !er});
    chk("dout_serial", g, {8'b0, o_s[g]}, {8'b0, ew});
    if (ev) begin
      exp_w.delete(key);
      exp_l.delete(key);
    end
  endtask

  // Downstream collector: rebuilds the frame from beats and compares on dout_last.
  task automatic collect(input int g);
    logic [15:0] want;
    if (o_v[g]) begin
      if (MSB) col[g] = ((col[g] << WI[g]) | 16'(o_s[g])) & fmask(g);
      else     col[g] = (col[g] >> WI[g]) | (16'(o_s[g]) << (WI[g] * (NI[g] - 1)));
      if (o_l[g]) begin
        want = (sent_q[g].size() > 0) ? sent_q[g].pop_front() : ~col[g];
        chk("loopback_frame", g, col[g], want);
        col[g] = '0;
      end
    end
  endtask

  task automatic drive(input int g);
    logic [15:0] f;
    if (!offering[g] && src_q[g].size() > 0 && (burst[g] || $urandom_range(0, 1) == 1))
      offering[g] = 1'b1;
    drv_v[g] = offering[g];
    drv_d[g] = offering[g] ? src_q[g][0] : 16'($urandom);
    if (offering[g] && rstn && cyc >= rdy_cyc[g]) begin
      f = src_q[g].pop_front() & fmask(g);
      for (int j = 0; j < NI[g]; j++) begin
        exp_w[(cyc + 1 + j) * 4 + g] = word_of(g, f, MSB ? NI[g] - 1 - j : j);
        exp_l[(cyc + 1 + j) * 4 + g] = (j == NI[g] - 1);
      end
      rdy_cyc[g]  = cyc + NI[g] + GI[g] + 1;
      last_acc[g] = cyc;
      sent_q[g].push_back(f);
      offering[g] = 1'b0;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    for (int g = 0; g < 3; g++) check_outputs(g);
    for (int g = 0; g < 3; g++) collect(g);
    for (int g = 0; g < 3; g++) drive(g);
    advance();
  endtask

  task automatic flush_model();
    exp_w.delete();
    exp_l.delete();
    for (int g = 0; g < 3; g++) begin
      sent_q[g].delete();
      col[g]      = '0;
      rdy_cyc[g]  = 0;
      offering[g] = 1'b0;
      drv_v[g]    = 1'b0;
    end
  endtask

  initial begin
    drv_d = '0;
    drv_v = '0;
    for (int g = 0; g < 3; g++) begin
      rdy_cyc[g] = 0; last_acc[g] = -1; offering[g] = 1'b0; burst[g] = 1'b1; col[g] = '0;
    end
    @(negedge clk);
    step();
    step();
    rstn = 1'b1;

    // Directed frames, valid held high so back-to-back behaviour is exercised.
    src_q[0].push_back(16'hA55A);
    src_q[0].push_back(16'h1122);
    src_q[0].push_back(16'h3344);
    src_q[1].push_back(16'($urandom));
    src_q[1].push_back(16'($urandom));
    src_q[2].push_back(16'h0009);
    src_q[2].push_back(16'h0006);
    repeat (25) step();

    // Asynchronous reset in the middle of a frame, after its first beat.
    last_acc[0] = -1;
    src_q[0].push_back(16'hBEEF);
    for (int i = 0; i < 20; i++) begin
      if (last_acc[0] >= 0 && cyc == last_acc[0] + 1) break;
      step();
    end
    chk("first_beat_reached", 0, 16'(cyc), 16'(last_acc[0] + 1));
    for (int g = 0; g < 3; g++) check_outputs(g);
    #2 rstn = 1'b0;
    #1 flush_model();
    for (int g = 0; g < 3; g++) check_outputs(g);
    advance();
    for (int g = 0; g < 3; g++) check_outputs(g);
    rstn = 1'b1;
    src_q[0].push_back(16'h0102);
    repeat (10) step();

    // Random frames with random offer timing.
    for (int g = 0; g < 3; g++) begin
      burst[g] = 1'b0;
      repeat (12) src_q[g].push_back(16'($urandom) & fmask(g));
    end
    repeat (250) step();

    for (int g = 0; g < 3; g++)
      chk("frames_drained", g, 16'(src_q[g].size() + sent_q[g].size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
